// File: rtl/fxp_div_pkg.sv
// Shared types and constants for the fixed-point divider: FSM states, round modes, exception bit positions.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

endpackage

// File: rtl/fxp_div_round.sv
// Combinational back end of the divider: rounds the truncated quotient, applies the sign,
// saturates on overflow and derives the OF/UF/NX flags.
module fxp_div_round
  import fxp_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16,
  parameter bit SIGNED    = 1'b1
) (
  input  logic [WIDTH+FRAC_BITS-1:0] q,
  input  logic [WIDTH:0]             r,
  input  logic [WIDTH-1:0]           mag_b,
  input  logic                       sign,
  input  logic [2:0]                 round_mode,
  output logic [WIDTH-1:0]           out,
  output logic [4:0]                 exceptions
);

  localparam int N = WIDTH + FRAC_BITS;
  localparam logic [WIDTH-1:0] MAX_VAL = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH+1:0] r2;
  logic [WIDTH+1:0] b_ext;
  logic             r_nz;
  logic             inc;
  logic             of;
  logic [N:0]       m;
  logic [N:0]       limit;
  logic [WIDTH-1:0] sat;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    r2    = {r, 1'b0};
    b_ext = {2'b00, mag_b};
    r_nz  = |r;
    inc   = 1'b0;
    case (round_mode)
      RM_RNE:  inc = (r2 > b_ext) || ((r2 == b_ext) && q[0]);
      RM_RDN:  inc = sign;
      RM_RUP:  inc = !sign;
      RM_RMM:  inc = (r2 >= b_ext);
      default: inc = 1'b0;
    endcase
    inc = inc && r_nz;
    m   = {1'b0, q} + (N+1)'(inc);

    // Largest representable magnitude: negative results reach one further than positive ones.
    limit = '0;
    if (SIGNED) begin
      limit[WIDTH-1] = 1'b1;
      if (!sign) limit = limit - (N+1)'(1);
    end else begin
      limit[WIDTH-1:0] = '1;
    end
    of  = (m > limit);
    sat = (SIGNED && sign) ? MIN_VAL : MAX_VAL;

    exceptions         = '0;
    exceptions[EXC_OF] = of;
    exceptions[EXC_UF] = (m == '0) && r_nz;
    exceptions[EXC_NX] = r_nz || of;
    out = of ? sat : (sign ? -m[WIDTH-1:0] : m[WIDTH-1:0]);
  end

endmodule

// File: rtl/fxp_divider.sv
// Iterative restoring radix-2 fixed-point divider, one quotient bit per cycle, with rounding,
// saturation and backpressure. Define FXP_DIV_REM_EN to add the signed remainder output `rem`.
module fxp_divider
  import fxp_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16,
  parameter bit SIGNED    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       round_mode,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [4:0]       exceptions
`ifdef FXP_DIV_REM_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]    LAST    = CW'(N - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [N-1:0]     dq;      // dividend bits shift out the top while quotient bits shift in below
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] mag_b;
  logic             sign;
  logic [2:0]       rm;
  logic [CW-1:0]    cnt;
`ifdef FXP_DIV_REM_EN
  logic             a_neg;
`endif

  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             accept;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   pr_next;
  logic             q_bit;
  logic [N-1:0]     dq_next;
  logic [WIDTH-1:0] rnd_out;
  logic [4:0]       rnd_exc;

  assign in_ready = (state == IDLE);

  always_comb begin
    a_neg_in = SIGNED && a[WIDTH-1];
    b_neg_in = SIGNED && b[WIDTH-1];
    mag_a_in = a_neg_in ? -a : a;
    mag_b_in = b_neg_in ? -b : b;
    accept   = in_valid && in_ready && !cancel;
    trial    = {pr, dq[N-1]};
    q_bit    = (trial >= {1'b0, mag_b});
    pr_next  = q_bit ? (trial - {1'b0, mag_b}) : trial;
    dq_next  = {dq[N-2:0], q_bit};
  end

  // The last iteration feeds the rounder directly so the result registers on the same edge.
  fxp_div_round #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .SIGNED    (SIGNED)
  ) u_round (
    .q          (dq_next),
    .r          (pr_next),
    .mag_b      (mag_b),
    .sign       (sign),
    .round_mode (rm),
    .out        (rnd_out),
    .exceptions (rnd_exc)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out        <= '0;
      exceptions <= '0;
      dq         <= '0;
      pr         <= '0;
      mag_b      <= '0;
      sign       <= 1'b0;
      rm         <= '0;
      cnt        <= '0;
`ifdef FXP_DIV_REM_EN
      a_neg      <= 1'b0;
      rem        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rm    <= round_mode;
            sign  <= a_neg_in ^ b_neg_in;
            mag_b <= mag_b_in;
            dq    <= N'(mag_a_in) << FRAC_BITS;
            pr    <= '0;
            cnt   <= '0;
`ifdef FXP_DIV_REM_EN
            a_neg <= a_neg_in;
`endif
            if (b == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              if (a == '0) begin
                out        <= '0;
                exceptions <= 5'b10000;
              end else begin
                out        <= a_neg_in ? MIN_VAL : MAX_VAL;
                exceptions <= 5'b01000;
              end
`ifdef FXP_DIV_REM_EN
              rem <= a;
`endif
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            dq  <= dq_next;
            pr  <= pr_next[WIDTH-1:0];
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              out        <= rnd_out;
              exceptions <= rnd_exc;
              out_valid  <= 1'b1;
              state      <= DONE;
`ifdef FXP_DIV_REM_EN
              rem <= a_neg ? -pr_next[WIDTH-1:0] : pr_next[WIDTH-1:0];
`endif
            end
          end
        end
        DONE: begin
          if (cancel || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_divider.sv
// Self-checking bench for fxp_divider at default parameters: directed vectors with literal
// expectations plus a per-cycle monitor driven by an arithmetic reference model.
module tb_fxp_divider;

  localparam int N = 48;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  round_mode = '0;
  logic        cancel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [4:0]  exceptions;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  exc;
    int          due;
  } exp_t;
  exp_t sb[$];

  fxp_divider dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .round_mode (round_mode),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .exceptions (exceptions)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer division of |a|*2^16 by |b|, then rounding by the mode's rule.
  function automatic logic [36:0] model(input logic [31:0] aa, input logic [31:0] bb,
                                        input logic [2:0] rr);
    longint unsigned ma, mb, num, qq, r, m, lim;
    logic sa, sgn, inc, of, uf, nx;
    logic [31:0] o;
    sa  = aa[31];
    sgn = aa[31] ^ bb[31];
    ma  = aa[31] ? (64'h1_0000_0000 - {32'h0, aa}) : {32'h0, aa};
    mb  = bb[31] ? (64'h1_0000_0000 - {32'h0, bb}) : {32'h0, bb};
    if (bb == 32'h0) begin
      if (aa == 32'h0) return {5'b10000, 32'h0};
      return {5'b01000, sa ? 32'h8000_0000 : 32'h7FFF_FFFF};
    end
    num = ma * 65536;
    qq  = num / mb;
    r   = num % mb;
    case (rr)
      3'd0:    inc = (2 * r > mb) || ((2 * r == mb) && (qq % 2 == 1));
      3'd2:    inc = sgn;
      3'd3:    inc = !sgn;
      3'd4:    inc = (2 * r >= mb);
      default: inc = 1'b0;
    endcase
    if (r == 0) inc = 1'b0;
    m   = qq + (inc ? 1 : 0);
    lim = sgn ? 64'h8000_0000 : 64'h7FFF_FFFF;
    of  = (m > lim);
    nx  = (r != 0) || of;
    uf  = (m == 0) && (r != 0);
    if (of)       o = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (sgn) o = 32'(64'h1_0000_0000 - m);
    else          o = m[31:0];
    return {1'b0, 1'b0, of, uf, nx, o};
  endfunction

  // Per-cycle compare process: handshake state, latency and result against the model queue.
  always @(negedge clk) begin
    cyc++;
    if (!rst_l) begin
      sb.delete();
    end else begin
      if (sb.size() == 0) begin
        check("mon_idle_valid", out_valid, 1'b0);
        check("mon_idle_ready", in_ready, 1'b1);
      end else begin
        check("mon_busy_ready", in_ready, 1'b0);
        check("mon_valid", out_valid, cyc >= sb[0].due);
        if (out_valid) begin
          check("mon_out", out, sb[0].out);
          check("mon_exc", exceptions, sb[0].exc);
        end
        if (cancel || (out_valid && out_ready)) void'(sb.pop_front());
      end
      if (in_valid && in_ready && !cancel) begin
        logic [36:0] e;
        e = model(a, b, round_mode);
        sb.push_back('{out: e[31:0], exc: e[36:32], due: cyc + ((b == 32'h0) ? 1 : N + 1)});
      end
    end
  end

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic [2:0] rr);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_ready", in_ready, 1'b1);
    a = aa; b = bb; round_mode = rr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [2:0] rr, input logic [31:0] eo, input logic [4:0] ee,
                        input int el);
    int lat;
    issue(aa, bb, rr);
    wait_valid(lat);
    check({nm, "_lat"}, lat, el);
    check({nm, "_out"}, out, eo);
    check({nm, "_exc"}, exceptions, ee);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] held_out;
    logic [4:0]  held_exc;

    // Pin the reference model itself against hand-computed values.
    check("model_6_2",    model(32'h0006_0000, 32'h0002_0000, 3'd0), {5'b00000, 32'h0003_0000});
    check("model_m12_4",  model(32'hFFF4_0000, 32'h0004_0000, 3'd0), {5'b00000, 32'hFFFD_0000});
    check("model_1_3rup", model(32'h0001_0000, 32'h0003_0000, 3'd3), {5'b00001, 32'h0000_5556});
    check("model_of",     model(32'h7FFF_0000, 32'h0000_0100, 3'd0), {5'b00101, 32'h7FFF_FFFF});

    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_l = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_exc", exceptions, 5'b0);

    run_op("div_6_2",     32'h0006_0000, 32'h0002_0000, 3'd0, 32'h0003_0000, 5'b00000, 49);
    run_op("div_m12_4",   32'hFFF4_0000, 32'h0004_0000, 3'd0, 32'hFFFD_0000, 5'b00000, 49);
    run_op("third_rne",   32'h0001_0000, 32'h0003_0000, 3'd0, 32'h0000_5555, 5'b00001, 49);
    run_op("third_rup",   32'h0001_0000, 32'h0003_0000, 3'd3, 32'h0000_5556, 5'b00001, 49);
    run_op("mthird_rdn",  32'hFFFF_0000, 32'h0003_0000, 3'd2, 32'hFFFF_AAAA, 5'b00001, 49);
    run_op("mthird_rtz",  32'hFFFF_0000, 32'h0003_0000, 3'd1, 32'hFFFF_AAAB, 5'b00001, 49);
    run_op("mthird_rsv",  32'hFFFF_0000, 32'h0003_0000, 3'd7, 32'hFFFF_AAAB, 5'b00001, 49);
    run_op("dz_pos",      32'h0001_0000, 32'h0000_0000, 3'd0, 32'h7FFF_FFFF, 5'b01000, 1);
    run_op("dz_neg",      32'hFFFF_0000, 32'h0000_0000, 3'd0, 32'h8000_0000, 5'b01000, 1);
    run_op("zero_zero",   32'h0000_0000, 32'h0000_0000, 3'd0, 32'h0000_0000, 5'b10000, 1);
    run_op("overflow",    32'h7FFF_0000, 32'h0000_0100, 3'd0, 32'h7FFF_FFFF, 5'b00101, 49);
    run_op("tie_even_uf", 32'h0000_0001, 32'h0002_0000, 3'd0, 32'h0000_0000, 5'b00011, 49);
    run_op("tie_rmm",     32'h0000_0001, 32'h0002_0000, 3'd4, 32'h0000_0001, 5'b00001, 49);
    run_op("tie_odd_rne", 32'h0000_0003, 32'h0002_0000, 3'd0, 32'h0000_0002, 5'b00001, 49);
    run_op("min_by_one",  32'h8000_0000, 32'h0001_0000, 3'd0, 32'h8000_0000, 5'b00000, 49);
    run_op("min_by_m1",   32'h8000_0000, 32'hFFFF_0000, 3'd0, 32'h7FFF_FFFF, 5'b00101, 49);

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(32'h0006_0000, 32'h0002_0000, 3'd0);
    wait_valid(lat);
    check("bp_lat", lat, 49);
    held_out = out;
    held_exc = exceptions;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_out_stable", out, 32'h0003_0000);
      check("bp_exc_stable", exceptions, held_exc);
      check("bp_valid_held", out_valid, 1'b1);
      check("bp_not_ready", in_ready, 1'b0);
    end
    check("bp_first_out", held_out, 32'h0003_0000);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);

    // Cancel mid-calculation: accept in cycle t, cancel in t+10.
    issue(32'h0001_0000, 32'h0003_0000, 3'd0);
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_ready", in_ready, 1'b1);
    check("cancel_valid", out_valid, 1'b0);
    repeat (60) @(posedge clk);

    // Cancel while idle must block acceptance.
    @(posedge clk); #1;
    cancel = 1'b1; in_valid = 1'b1; a = 32'h0006_0000; b = 32'h0002_0000;
    @(posedge clk); #1;
    cancel = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_cancel_block", in_ready, 1'b1);

    // Asynchronous reset mid-calculation clears every output at once.
    run_op("pre_rst", 32'h0001_0000, 32'h0003_0000, 3'd3, 32'h0000_5556, 5'b00001, 49);
    issue(32'hFFFF_0000, 32'h0003_0000, 3'd0);
    repeat (20) @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    check("arst_out", out, 32'h0);
    check("arst_exc", exceptions, 5'b0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;

    run_op("post_rst", 32'h0006_0000, 32'h0002_0000, 3'd0, 32'h0003_0000, 5'b00000, 49);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
